// File: rtl/muladd_pkg.sv
// rtl/muladd_pkg.sv - shared widths, pipeline depth and operand bundle for the muladd issue controller
//
// Purpose:
//   Common definitions used by muladd_issue_ctrl and muladd_result_fifo.
//   A_W/B_W/C_W/Y_W are the DSP operand and result widths. DSP_LAT is the
//   number of registered stages between the A/B inputs and P, i.e. the
//   length of the token shift register that tracks in-flight operations.
// Ports: none (package).
package muladd_pkg;

  localparam int A_W     = 8;
  localparam int B_W     = 8;
  localparam int C_W     = 16;
  localparam int Y_W     = 16;
  localparam int DSP_LAT = 3;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
  } operand_t;

endpackage : muladd_pkg

// File: rtl/muladd_result_fifo.sv
// rtl/muladd_result_fifo.sv - synchronous result FIFO with registered head
//
// Purpose:
//   Buffers DSP results until the downstream consumer takes them. The head
//   entry is read straight out of the storage registers, so the output is
//   registered and a pushed word becomes visible the cycle after the push.
//   No bypass: a push into an empty FIFO is not visible in the same cycle.
//   Push and pop in the same cycle are allowed, including when full; the
//   popped slot is the one being overwritten, which is safe because its
//   data is consumed on that same edge.
//
// Parameters:
//   DEPTH  number of entries, power of two, >= 2
//   W      data width
//
// Ports:
//   clock      in   clock
//   reset      in   synchronous active-low reset (empties the FIFO)
//   push       in   write push_data at the tail
//   push_data  in   W-bit data to write
//   pop        in   discard the head entry
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   head       out  oldest entry (valid when !empty)
module muladd_result_fifo
  import muladd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = Y_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_DEPTH = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never presented while empty.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign full  = (count_q == CNT_DEPTH);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule : muladd_result_fifo

// File: rtl/muladd_issue_ctrl.sv
// rtl/muladd_issue_ctrl.sv - stream issue/capture controller around a fused multiply-add DSP stage
//
// Purpose:
//   Feeds operand triples into an external DSP computing y = a*b + c with
//   registered A/B, M and P stages (C unregistered, one shared enable),
//   delays c by two enabled cycles so it meets M at the P register, tracks
//   in-flight tokens and captures valid P outputs into a result FIFO that
//   drives the output stream. When the FIFO is full and P holds a valid
//   result nobody can take, the whole DSP pipeline freezes via dsp_en.
//   The pipeline also advances on bubbles so results drain without input.
//
// Optional feature (macro MULADD_ISSUE_PERF_EN):
//   Adds perf_issued (accepted triples) and perf_stall (cycles with
//   in_valid & !in_ready), both cleared by reset and wrapping at 2^32.
//
// Parameters:
//   FIFO_DEPTH  result FIFO entries, power of two, >= 2
//
// Ports:
//   clock        in   single clock
//   reset        in   synchronous active-low reset
//   in_valid     in   operand triple valid
//   in_ready     out  operand triple accepted when in_valid & in_ready
//   in_a/in_b    in   multiplicand / multiplier
//   in_c         in   addend
//   dsp_a/dsp_b  out  combinational copies of in_a/in_b to DSP A/B
//   dsp_c        out  addend aligned to the P-load edge
//   dsp_en       out  shared DSP clock enable
//   dsp_y        in   DSP P output
//   out_valid    out  result available
//   out_ready    in   result consumed when out_valid & out_ready
//   out_y        out  (a*b + c) mod 2^16, registered FIFO head
//   perf_issued  out  (MULADD_ISSUE_PERF_EN only) accepted triple count
//   perf_stall   out  (MULADD_ISSUE_PERF_EN only) stalled cycle count
module muladd_issue_ctrl
  import muladd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  input  logic [C_W-1:0] in_c,
  output logic [A_W-1:0] dsp_a,
  output logic [B_W-1:0] dsp_b,
  output logic [C_W-1:0] dsp_c,
  output logic           dsp_en,
  input  logic [Y_W-1:0] dsp_y,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef MULADD_ISSUE_PERF_EN
  output logic [31:0]    perf_issued,
  output logic [31:0]    perf_stall,
`endif
  output logic [Y_W-1:0] out_y
);

  operand_t           op;
  logic [DSP_LAT-1:0] vld_q, vld_d;
  logic [C_W-1:0]     c_d1_q, c_d1_d;
  logic [C_W-1:0]     c_d2_q, c_d2_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;

  assign op = '{a: in_a, b: in_b, c: in_c};

  assign dsp_a = op.a;
  assign dsp_b = op.b;
  assign dsp_c = c_d2_q;

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid & out_ready;

  // Freeze only when P holds a valid result that cannot be stored: a
  // bubble in P, free FIFO space, or a same-cycle pop all let it advance.
  assign dsp_en   = !vld_q[DSP_LAT-1] | !fifo_full | fifo_pop;
  assign in_ready = dsp_en;

  // P is captured only on an advancing edge, so a frozen P is pushed once.
  assign fifo_push = vld_q[DSP_LAT-1] & dsp_en;

  always_comb begin
    vld_d  = vld_q;
    c_d1_d = c_d1_q;
    c_d2_d = c_d2_q;
    if (dsp_en) begin
      // Bubbles enter as in_valid = 0 so the token chain mirrors A/B -> M -> P.
      vld_d  = {vld_q[DSP_LAT-2:0], in_valid};
      // Two stages: c must arrive at the C pin on the edge M loads into P.
      c_d1_d = op.c;
      c_d2_d = c_d1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q  <= '0;
      c_d1_q <= '0;
      c_d2_q <= '0;
    end else begin
      vld_q  <= vld_d;
      c_d1_q <= c_d1_d;
      c_d2_q <= c_d2_d;
    end
  end

  muladd_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (Y_W)
  ) u_result_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (dsp_y),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_y)
  );

`ifdef MULADD_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (in_valid && in_ready) begin
      perf_issued_d = perf_issued_q + 32'd1;
    end
    if (in_valid && !in_ready) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule : muladd_issue_ctrl

// File: tb/tb_muladd_issue_ctrl.sv
// tb/tb_muladd_issue_ctrl.sv - scoreboard bench for muladd_issue_ctrl with a behavioural DSP
module tb_muladd_issue_ctrl;

  localparam int DEPTH = 4;

  logic        clock     = 1'b0;
  logic        reset     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a      = '0;
  logic [7:0]  in_b      = '0;
  logic [15:0] in_c      = '0;
  logic [7:0]  dsp_a;
  logic [7:0]  dsp_b;
  logic [15:0] dsp_c;
  logic        dsp_en;
  logic [15:0] dsp_y;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;
`ifdef MULADD_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int total = 0;
  int bad = 0;
  int accepted = 0;
  int stalls = 0;
  int delivered = 0;
  logic [15:0] exp_q[$];

  always #5 clock = ~clock;

  muladd_issue_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_c     (dsp_c),
    .dsp_en    (dsp_en),
    .dsp_y     (dsp_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MULADD_ISSUE_PERF_EN
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
`endif
    .out_y     (out_y)
  );

  // Behavioural DSP: A/B regs, M reg, P reg, unregistered C, shared enable.
  logic [7:0]  a_r, b_r;
  logic [15:0] m_r, p_r;
  always @(posedge clock) begin
    if (dsp_en) begin
      a_r <= dsp_a;
      b_r <= dsp_b;
      m_r <= a_r * b_r;
      p_r <= m_r + dsp_c;
    end
  end
  assign dsp_y = p_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every handshake on the output stream is compared against the queue head.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset && out_valid && out_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%0h required=none", out_y);
        end else begin
          chk("out_y", {16'h0, out_y}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // One clock of stimulus; the reference result is plain modular arithmetic.
  task automatic cycle(input int iv, input int a, input int b, input int c, input int ordy);
    @(negedge clock);
    in_valid  = (iv != 0);
    in_a      = a[7:0];
    in_b      = b[7:0];
    in_c      = c[15:0];
    out_ready = (ordy != 0);
    #2;
    if (reset) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(16'((a & 255) * (b & 255) + (c & 65535)));
        accepted++;
      end
      if (in_valid && !in_ready) stalls++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 1);
  endtask

  int d0, s0, a0;

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_dsp_c", {16'h0, dsp_c}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_dsp_en", {31'h0, dsp_en}, 1);
    @(negedge clock);
    reset = 1'b1;

    // Single op with latency check
    d0 = delivered;
    cycle(1, 3, 5, 7, 1);
    chk("t1_dsp_a_copy", {24'h0, dsp_a}, 3);
    chk("t1_dsp_b_copy", {24'h0, dsp_b}, 5);
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 0, 0, 1);
      chk($sformatf("t1_valid_edge%0d", k), {31'h0, out_valid}, (k == 4) ? 1 : 0);
    end
    chk("t1_out_y", {16'h0, out_y}, 32'h16);
    idle(4);
    chk("t1_count", delivered - d0, 1);

    // Streaming, one result per cycle
    d0 = delivered;
    s0 = stalls;
    for (int i = 0; i < 8; i++) cycle(1, i, i + 1, 100 * i, 1);
    chk("t2_no_stall", stalls - s0, 0);
    idle(3);
    chk("t2_count_early", delivered - d0, 7);
    idle(1);
    chk("t2_count", delivered - d0, 8);

    // Back-pressure: FIFO plus pipeline absorb DEPTH+DSP_LAT, then freeze
    d0 = delivered;
    s0 = stalls;
    a0 = accepted;
    for (int i = 0; i < 12; i++) cycle(1, $urandom, $urandom, $urandom, 0);
    chk("t3_accepted", accepted - a0, DEPTH + 3);
    chk("t3_stalls", stalls - s0, 12 - (DEPTH + 3));
    chk("t3_in_ready_low", {31'h0, in_ready}, 0);
    chk("t3_dsp_en_low", {31'h0, dsp_en}, 0);
    chk("t3_none_out", delivered - d0, 0);
    chk("t3_out_valid", {31'h0, out_valid}, 1);

    // Full with vld[2] = 1: a pop lets the pipeline advance, occupancy unchanged
    cycle(1, $urandom, $urandom, $urandom, 1);
    chk("t6_dsp_en", {31'h0, dsp_en}, 1);
    chk("t6_in_ready", {31'h0, in_ready}, 1);
    cycle(1, $urandom, $urandom, $urandom, 0);
    chk("t6_still_full", {31'h0, in_ready}, 0);
    idle(16);
    chk("t3_drained", delivered - d0, DEPTH + 4);
    chk("t3_queue_empty", exp_q.size(), 0);
`ifdef MULADD_ISSUE_PERF_EN
    chk("perf_stall", perf_stall, stalls);
    chk("perf_issued", perf_issued, accepted);
`endif

    // Wrap
    cycle(1, 255, 255, 65535, 1);
    idle(4);
    chk("t4_valid", {31'h0, out_valid}, 1);
    chk("t4_out_y", {16'h0, out_y}, 32'hFE00);
    idle(2);

    // Reset mid-flight discards in-flight tokens
    cycle(1, 1, 2, 3, 1);
    cycle(1, 4, 5, 6, 1);
    cycle(1, 7, 8, 9, 1);
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2;
    exp_q.delete();
    accepted = 0;
    stalls = 0;
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("t5_valid_after_rst", {31'h0, out_valid}, 0);
    chk("t5_dsp_c_after_rst", {16'h0, dsp_c}, 0);
    d0 = delivered;
    idle(5);
    chk("t5_no_stale", delivered - d0, 0);
    chk("t5_still_empty", {31'h0, out_valid}, 0);
    cycle(1, 2, 2, 1, 1);
    idle(4);
    chk("t5_out_y", {16'h0, out_y}, 5);
    idle(4);
    chk("t5_count", delivered - d0, 1);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 1), $urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0) ? 1 : 0);
    end
    idle(20);
    chk("rand_drained", exp_q.size(), 0);
`ifdef MULADD_ISSUE_PERF_EN
    chk("rand_perf_issued", perf_issued, accepted);
    chk("rand_perf_stall", perf_stall, stalls);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_muladd_issue_ctrl
